// File: rtl/seg7_scan_rx.sv
// Display-bus monitor: samples a multiplexed 7-segment scan, rejects unsettled values
// and reassembles every complete scan into a frame of decoded hex digits.
module seg7_scan_rx #(
  parameter int N_DIGITS = 8,
  parameter int SETTLE   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_DIGITS-1:0]   seg7_sel,
  input  logic [7:0]            seg7,
  input  logic                  clr_err,
  output logic [4*N_DIGITS-1:0] digits,
  output logic [N_DIGITS-1:0]   dp,
  output logic [N_DIGITS-1:0]   blank,
  output logic                  frame_valid,
  output logic                  err_pattern,
  output logic                  err_sel
);
  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  state_t                state_q;
  logic [N_DIGITS-1:0]   s_sel_q;
  logic [7:0]            s_seg_q;
  logic [3:0]            stab_q;
  logic                  chg_q;
  logic [4*N_DIGITS-1:0] digits_q;
  logic [N_DIGITS-1:0]   dp_q;
  logic [N_DIGITS-1:0]   blank_q;
  logic                  frame_valid_q;
  logic                  err_pattern_q;
  logic                  err_sel_q;

  logic [4*N_DIGITS-1:0] nib_sh;
  logic [N_DIGITS-1:0]   dp_sh;
  logic [N_DIGITS-1:0]   blank_sh;
  logic [N_DIGITS-1:0]   seen_vec;

  logic                  eval_go;
  logic                  sel_zero;
  logic                  sel_onehot;
  logic                  cap_go;
  logic                  frame_done;
  logic [3:0]            dec_nib_d;
  logic                  dec_ok_d;
  logic                  dec_blank_d;

  // stab_q counts how many consecutive identical samples s_*_q has been; chg_q flags a fresh value
  always_ff @(posedge clk) begin
    if (rst) begin
      s_sel_q <= '0;
      s_seg_q <= '0;
      stab_q  <= '0;
      chg_q   <= 1'b0;
    end else begin
      s_sel_q <= seg7_sel;
      s_seg_q <= seg7;
      if ({seg7_sel, seg7} == {s_sel_q, s_seg_q}) begin
        chg_q <= 1'b0;
        if (stab_q != SETTLE_C) stab_q <= stab_q + 4'd1;
      end else begin
        chg_q  <= 1'b1;
        stab_q <= 4'd1;
      end
    end
  end

  assign sel_zero   = (s_sel_q == '0);
  assign sel_onehot = !sel_zero && ((s_sel_q & (s_sel_q - N_DIGITS'(1))) == '0);
  assign eval_go    = (state_q == S_WAIT) && (stab_q == SETTLE_C);
  assign cap_go     = eval_go && sel_onehot;
  assign frame_done = &seen_vec;

  always_comb begin
    dec_nib_d   = 4'h0;
    dec_ok_d    = 1'b1;
    dec_blank_d = (s_seg_q[6:0] == 7'h00);
    case (s_seg_q[6:0])
      7'h3F:   dec_nib_d = 4'h0;
      7'h06:   dec_nib_d = 4'h1;
      7'h5B:   dec_nib_d = 4'h2;
      7'h4F:   dec_nib_d = 4'h3;
      7'h66:   dec_nib_d = 4'h4;
      7'h6D:   dec_nib_d = 4'h5;
      7'h7D:   dec_nib_d = 4'h6;
      7'h07:   dec_nib_d = 4'h7;
      7'h7F:   dec_nib_d = 4'h8;
      7'h6F:   dec_nib_d = 4'h9;
      7'h77:   dec_nib_d = 4'hA;
      7'h7C:   dec_nib_d = 4'hB;
      7'h39:   dec_nib_d = 4'hC;
      7'h5E:   dec_nib_d = 4'hD;
      7'h79:   dec_nib_d = 4'hE;
      7'h71:   dec_nib_d = 4'hF;
      7'h00:   dec_nib_d = 4'h0;
      default: dec_ok_d  = 1'b0;
    endcase
  end

  // Per-digit shadow: a capture always wins over the frame-complete clear of seen
  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
    logic [3:0] nib_q;
    logic       dp_sh_q;
    logic       blank_sh_q;
    logic       seen_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        nib_q      <= 4'h0;
        dp_sh_q    <= 1'b0;
        blank_sh_q <= 1'b0;
        seen_q     <= 1'b0;
      end else if (cap_go && s_sel_q[gi]) begin
        nib_q      <= dec_nib_d;
        dp_sh_q    <= s_seg_q[7];
        blank_sh_q <= dec_blank_d;
        seen_q     <= 1'b1;
      end else if (frame_done) begin
        seen_q     <= 1'b0;
      end
    end

    assign nib_sh[4*gi +: 4] = nib_q;
    assign dp_sh[gi]         = dp_sh_q;
    assign blank_sh[gi]      = blank_sh_q;
    assign seen_vec[gi]      = seen_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      digits_q      <= '0;
      dp_q          <= '0;
      blank_q       <= '0;
      frame_valid_q <= 1'b0;
      err_pattern_q <= 1'b0;
      err_sel_q     <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      if (frame_done) begin
        digits_q      <= nib_sh;
        dp_q          <= dp_sh;
        blank_q       <= blank_sh;
        frame_valid_q <= 1'b1;
      end
      case (state_q)
        S_IDLE:  if (!sel_zero) state_q <= S_WAIT;
        S_WAIT:  if (stab_q == SETTLE_C) state_q <= S_HOLD;
        S_HOLD:  if (chg_q) state_q <= sel_zero ? S_IDLE : S_WAIT;
        default: state_q <= S_IDLE;
      endcase
      // A new error in the same cycle as clr_err keeps the flag set
      err_pattern_q <= (err_pattern_q & ~clr_err) | (cap_go & ~dec_ok_d);
      err_sel_q     <= (err_sel_q & ~clr_err) | (eval_go & ~sel_zero & ~sel_onehot);
    end
  end

  assign digits      = digits_q;
  assign dp          = dp_q;
  assign blank       = blank_q;
  assign frame_valid = frame_valid_q;
  assign err_pattern = err_pattern_q;
  assign err_sel     = err_sel_q;
endmodule

// File: tb/tb_seg7_scan_rx.sv
// Bench for seg7_scan_rx: drives scanned frames and compares every emitted frame
// against a queue of expected frames, plus inline checks of flags and frame counts.
module tb_seg7_scan_rx;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  seg7_sel = '0;
  logic [7:0]  seg7 = '0;
  logic        clr_err = 1'b0;
  logic [31:0] digits;
  logic [7:0]  dp;
  logic [7:0]  blank;
  logic        frame_valid;
  logic        err_pattern;
  logic        err_sel;

  int checks = 0;
  int errors = 0;
  int frame_cnt = 0;
  logic fv_prev = 1'b0;

  typedef struct packed {
    logic [31:0] d;
    logic [7:0]  dp;
    logic [7:0]  bl;
  } frame_t;
  frame_t exp_q[$];
  frame_t mon_e;

  logic [6:0] lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg7_scan_rx #(.N_DIGITS(8), .SETTLE(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg7_sel    (seg7_sel),
    .seg7        (seg7),
    .clr_err     (clr_err),
    .digits      (digits),
    .dp          (dp),
    .blank       (blank),
    .frame_valid (frame_valid),
    .err_pattern (err_pattern),
    .err_sel     (err_sel)
  );

  always #5 clk = ~clk;

  // Scoreboard: every frame_valid pops one expected frame
  always @(negedge clk) begin
    if (frame_valid) begin
      frame_cnt++;
      $display("frame %0d: digits=%h dp=%h blank=%h", frame_cnt, digits, dp, blank);
      checks++;
      if (fv_prev) begin
        errors++;
        $display("FAIL frame_pulse: frame_valid high 2 cycles, required 1");
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL frame_unexpected: digits=%h dp=%h blank=%h, required no frame", digits, dp, blank);
      end else begin
        mon_e = exp_q.pop_front();
        if ({digits, dp, blank} !== mon_e) begin
          errors++;
          $display("FAIL frame_data: got digits=%h dp=%h blank=%h, required digits=%h dp=%h blank=%h",
                   digits, dp, blank, mon_e.d, mon_e.dp, mon_e.bl);
        end
      end
    end
    fv_prev = frame_valid;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [7:0] sel, input logic [7:0] seg, input int n);
    seg7_sel = sel;
    seg7     = seg;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan_digit(input int i, input logic [7:0] seg, input bit glitch);
    drive(8'(1 << i), seg, 4);
    if (glitch) drive(8'($urandom), 8'($urandom), 1);
    drive(8'h00, 8'h00, 1);
  endtask

  task automatic scan_frame(input logic [31:0] val, input logic [7:0] dpm, input bit glitch);
    exp_q.push_back({val, dpm, 8'h00});
    for (int i = 0; i < 8; i++) begin
      logic [3:0] nib;
      nib = val[4*i +: 4];
      scan_digit(i, {dpm[i], lut[nib]}, glitch);
    end
  endtask

  task automatic wait_frames(input int target);
    int n;
    n = 0;
    while (frame_cnt < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    #1;
    checks++;
    if (frame_cnt < target) begin
      errors++;
      $display("FAIL frame_timeout: got %0d frames, required %0d", frame_cnt, target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(8'h00, 8'h00, 3);
    rst = 1'b0;
    drive(8'h00, 8'h00, 2);
    checks++;
    if ({digits, dp, blank} !== 48'h0) begin
      errors++;
      $display("FAIL reset_frame: got %h, required 0", {digits, dp, blank});
    end
    checks++;
    if ({frame_valid, err_pattern, err_sel} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 000", {frame_valid, err_pattern, err_sel});
    end
  endtask

  task automatic test_scan();
    int fc;
    fc = frame_cnt;
    scan_frame(32'h87654321, 8'h00, 1'b0);
    wait_frames(fc + 1);
    checks++;
    if ({err_pattern, err_sel} !== 2'b00) begin
      errors++;
      $display("FAIL scan_errs: got %b, required 00", {err_pattern, err_sel});
    end
  endtask

  task automatic test_glitch();
    int fc;
    fc = frame_cnt;
    scan_frame(32'h87654321, 8'h00, 1'b1);
    wait_frames(fc + 1);
    drive(8'h00, 8'h00, 10);
    checks++;
    if (frame_cnt !== fc + 1) begin
      errors++;
      $display("FAIL glitch_count: got %0d frames, required %0d", frame_cnt, fc + 1);
    end
    checks++;
    if ({err_pattern, err_sel} !== 2'b00) begin
      errors++;
      $display("FAIL glitch_errs: got %b, required 00", {err_pattern, err_sel});
    end
  endtask

  task automatic test_blank_err();
    int fc;
    fc = frame_cnt;
    exp_q.push_back({32'h87050321, 8'h08, 8'h08});
    for (int i = 0; i < 8; i++) begin
      if (i == 3)      scan_digit(i, 8'h80, 1'b0);
      else if (i == 5) scan_digit(i, 8'h40, 1'b0);
      else             scan_digit(i, {1'b0, lut[i + 1]}, 1'b0);
    end
    wait_frames(fc + 1);
    checks++;
    if ({err_pattern, err_sel} !== 2'b10) begin
      errors++;
      $display("FAIL pattern_err: got %b, required 10", {err_pattern, err_sel});
    end
  endtask

  task automatic test_clr_err();
    drive(8'h00, 8'h00, 5);
    checks++;
    if (err_pattern !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %b, required 1", err_pattern);
    end
    clr_err = 1'b1;
    drive(8'h00, 8'h00, 1);
    clr_err = 1'b0;
    checks++;
    if (err_pattern !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: got %b, required 0", err_pattern);
    end
  endtask

  task automatic test_err_sel();
    int fc;
    fc = frame_cnt;
    exp_q.push_back({32'h0FEDCBA9, 8'h00, 8'h00});
    for (int i = 0; i < 4; i++) scan_digit(i, {1'b0, lut[9 + i]}, 1'b0);
    drive(8'h03, 8'h06, 5);
    drive(8'h00, 8'h00, 1);
    checks++;
    if (err_sel !== 1'b1) begin
      errors++;
      $display("FAIL sel_err: got %b, required 1", err_sel);
    end
    checks++;
    if (frame_cnt !== fc) begin
      errors++;
      $display("FAIL sel_noframe: got %0d frames, required %0d", frame_cnt, fc);
    end
    for (int i = 4; i < 8; i++) scan_digit(i, {1'b0, lut[(9 + i) % 16]}, 1'b0);
    wait_frames(fc + 1);
    checks++;
    if (err_pattern !== 1'b0) begin
      errors++;
      $display("FAIL sel_pattern: got %b, required 0", err_pattern);
    end
  endtask

  task automatic test_mid_reset();
    int fc;
    for (int i = 4; i < 8; i++) scan_digit(i, {1'b0, lut[7]}, 1'b0);
    rst = 1'b1;
    drive(8'h00, 8'h00, 2);
    rst = 1'b0;
    drive(8'h00, 8'h00, 1);
    checks++;
    if ({digits, dp, blank, frame_valid, err_pattern, err_sel} !== 51'h0) begin
      errors++;
      $display("FAIL midrst_clear: got digits=%h errs=%b, required all 0", digits, {err_pattern, err_sel});
    end
    fc = frame_cnt;
    scan_frame(32'h13579BDF, 8'h81, 1'b0);
    wait_frames(fc + 1);
    drive(8'h00, 8'h00, 20);
    checks++;
    if (frame_cnt !== fc + 1) begin
      errors++;
      $display("FAIL midrst_count: got %0d frames, required %0d", frame_cnt, fc + 1);
    end
  endtask

  task automatic test_overwrite();
    int fc;
    fc = frame_cnt;
    exp_q.push_back({32'h76543510, 8'h00, 8'h00});
    scan_digit(0, {1'b0, lut[0]}, 1'b0);
    scan_digit(1, {1'b0, lut[1]}, 1'b0);
    scan_digit(2, {1'b0, lut[10]}, 1'b0);
    for (int i = 3; i < 7; i++) scan_digit(i, {1'b0, lut[i]}, 1'b0);
    scan_digit(2, {1'b0, lut[5]}, 1'b0);
    scan_digit(7, {1'b0, lut[7]}, 1'b0);
    wait_frames(fc + 1);
  endtask

  task automatic test_back_to_back();
    int fc;
    fc = frame_cnt;
    scan_frame(32'hDEADBEEF, 8'hA5, 1'b0);
    scan_frame(32'h01234567, 8'h5A, 1'b0);
    wait_frames(fc + 2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_pending: got %0d frames outstanding, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_glitch();
    test_blank_err();
    test_clr_err();
    test_err_sel();
    test_mid_reset();
    test_overwrite();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
